// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver: one digit per slot, a blank
// window at the start of each slot, and 4-bit PWM brightness gating.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic [6:0] dg1,
    input  logic [6:0] dg2,
    input  logic [6:0] dg3,
    input  logic [6:0] dg4,
    input  logic [3:0] DpIn,
    input  logic [3:0] Brightness,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] An,
    output logic       FrameTick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [6:0]    pat_q, pat_d;
    logic          dpl_q, dpl_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;

    logic [6:0] dg_arr [4];
    logic [3:0] an_sel_n;
    logic       cnt_last;
    logic       gate;
    logic       active;

    assign dg_arr[0] = dg1;
    assign dg_arr[1] = dg2;
    assign dg_arr[2] = dg3;
    assign dg_arr[3] = dg4;

    // Active-low one-hot anode for the digit currently being scanned.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_an
            assign an_sel_n[gi] = (idx_q != 2'(gi));
        end
    endgenerate

    assign cnt_last = (cnt_q == CNT_LAST);
    assign gate     = (Brightness == 4'hF) || (pwm_q < Brightness);
    assign active   = (cnt_q >= CNT_BLANK) && gate;

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pwm_d   = pwm_q;
        pat_d   = pat_q;
        dpl_d   = dpl_q;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        an_d    = 4'hF;
        frame_d = 1'b0;
        if (!Enable) begin
            cnt_d = '0;
            idx_d = 2'd0;
            pwm_d = 4'd0;
        end else begin
            cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
            idx_d   = cnt_last ? idx_q + 2'd1 : idx_q;
            pwm_d   = pwm_q + 4'd1;
            frame_d = cnt_last && (idx_q == 2'd3);
            // Latch only at slot start so mid-slot input changes cannot leak.
            if (cnt_q == '0) begin
                pat_d = dg_arr[idx_q];
                dpl_d = DpIn[idx_q];
            end
            if (active) begin
                an_d  = an_sel_n;
                seg_d = pat_q;
                dp_d  = ~dpl_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            pwm_q   <= 4'd0;
            pat_q   <= 7'h7F;
            dpl_q   <= 1'b0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= 4'hF;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pwm_q   <= pwm_d;
            pat_q   <= pat_d;
            dpl_q   <= dpl_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign Seg       = seg_q;
    assign Dp        = dp_q;
    assign An        = an_q;
    assign FrameTick = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV = 8, BLANK_CYC = 2.
module tb_seg_scan_driver;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Enable = 1'b0;
    logic [6:0] dg1 = 7'h40;
    logic [6:0] dg2 = 7'h79;
    logic [6:0] dg3 = 7'h24;
    logic [6:0] dg4 = 7'h30;
    logic [3:0] DpIn = 4'h0;
    logic [3:0] Brightness = 4'hF;
    logic [6:0] Seg;
    logic       Dp;
    logic [3:0] An;
    logic       FrameTick;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [6:0] pats [4];

    seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable),
        .dg1(dg1), .dg2(dg2), .dg3(dg3), .dg4(dg4),
        .DpIn(DpIn), .Brightness(Brightness),
        .Seg(Seg), .Dp(Dp), .An(An), .FrameTick(FrameTick)
    );

    always #5 CLK = ~CLK;

    // Anode expected after edge k of a scan started at Cnt=0, Idx=0.
    function automatic logic [3:0] exp_an(input int k, input bit gate);
        int c = k % 8;
        int d = (k / 8) % 4;
        logic [3:0] one = 4'b0001 << d;
        if (c >= 2 && gate) return ~one;
        return 4'hF;
    endfunction

    function automatic logic [6:0] exp_seg(input int k, input bit gate);
        if (exp_an(k, gate) == 4'hF) return 7'h7F;
        return pats[(k / 8) % 4];
    endfunction

    // Clear the scan with one Enable-low clock, then re-enable at a negedge.
    task automatic restart();
        @(negedge CLK);
        Enable = 1'b0;
        @(negedge CLK);
        Enable = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        Enable = 1'b0;
        #12;
        total_cnt++;
        if (An !== 4'hF) $display("FAIL reset_an got %h want F", An); else pass_cnt++;
        total_cnt++;
        if (Seg !== 7'h7F) $display("FAIL reset_seg got %h want 7F", Seg); else pass_cnt++;
        total_cnt++;
        if (Dp !== 1'b1) $display("FAIL reset_dp got %b want 1", Dp); else pass_cnt++;
        total_cnt++;
        if (FrameTick !== 1'b0) $display("FAIL reset_ft got %b want 0", FrameTick); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_scan();
        @(negedge CLK);
        RST = 1'b0;
        Enable = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge CLK);
            total_cnt++;
            if (An !== exp_an(k, 1'b1))
                $display("FAIL scan_an k=%0d got %h want %h", k, An, exp_an(k, 1'b1));
            else pass_cnt++;
            total_cnt++;
            if (Seg !== exp_seg(k, 1'b1))
                $display("FAIL scan_seg k=%0d got %h want %h", k, Seg, exp_seg(k, 1'b1));
            else pass_cnt++;
            total_cnt++;
            if (FrameTick !== ((k % 32) == 31))
                $display("FAIL scan_ft k=%0d got %b want %b", k, FrameTick, (k % 32) == 31);
            else pass_cnt++;
            total_cnt++;
            if (Dp !== 1'b1) $display("FAIL scan_dp k=%0d got %b want 1", k, Dp); else pass_cnt++;
        end
        $display("test_scan done");
    endtask

    task automatic test_dp();
        DpIn = 4'b0100;
        restart();
        for (int k = 0; k < 32; k++) begin
            @(negedge CLK);
            total_cnt++;
            if (Dp !== (exp_an(k, 1'b1) != 4'hB))
                $display("FAIL dp k=%0d got %b want %b an=%h", k, Dp, exp_an(k, 1'b1) != 4'hB, An);
            else pass_cnt++;
        end
        DpIn = 4'h0;
        $display("test_dp done");
    endtask

    task automatic test_brightness();
        Brightness = 4'd4;
        restart();
        for (int k = 0; k < 64; k++) begin
            @(negedge CLK);
            total_cnt++;
            if (An !== exp_an(k, (k % 16) < 4))
                $display("FAIL bright4_an k=%0d got %h want %h", k, An, exp_an(k, (k % 16) < 4));
            else pass_cnt++;
        end
        Brightness = 4'd0;
        restart();
        for (int k = 0; k < 64; k++) begin
            @(negedge CLK);
            total_cnt++;
            if (An !== 4'hF) $display("FAIL bright0_an k=%0d got %h want F", k, An); else pass_cnt++;
        end
        Brightness = 4'hF;
        $display("test_brightness done");
    endtask

    task automatic test_midslot_change();
        restart();
        for (int k = 0; k < 48; k++) begin
            @(negedge CLK);
            if (k == 12) dg2 = 7'h00;
            if (k >= 10 && k < 16) begin
                total_cnt++;
                if (Seg !== 7'h79) $display("FAIL mid_seg_old k=%0d got %h want 79", k, Seg); else pass_cnt++;
            end
            if (k >= 42 && k < 48) begin
                total_cnt++;
                if (Seg !== 7'h00) $display("FAIL mid_seg_new k=%0d got %h want 00", k, Seg); else pass_cnt++;
            end
        end
        dg2 = 7'h79;
        $display("test_midslot_change done");
    endtask

    task automatic test_enable_drop();
        restart();
        for (int k = 0; k < 20; k++) @(negedge CLK);
        total_cnt++;
        if (An !== 4'hB) $display("FAIL drop_pre_an got %h want B", An); else pass_cnt++;
        Enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge CLK);
            total_cnt++;
            if (An !== 4'hF) $display("FAIL drop_an j=%0d got %h want F", j, An); else pass_cnt++;
            total_cnt++;
            if (Seg !== 7'h7F) $display("FAIL drop_seg j=%0d got %h want 7F", j, Seg); else pass_cnt++;
            total_cnt++;
            if (Dp !== 1'b1 || FrameTick !== 1'b0)
                $display("FAIL drop_dp_ft j=%0d got %b%b want 10", j, Dp, FrameTick);
            else pass_cnt++;
        end
        Enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            total_cnt++;
            if (An !== exp_an(k, 1'b1) || Seg !== exp_seg(k, 1'b1))
                $display("FAIL reen k=%0d got %h/%h want %h/%h", k, An, Seg, exp_an(k, 1'b1), exp_seg(k, 1'b1));
            else pass_cnt++;
        end
        $display("test_enable_drop done");
    endtask

    task automatic test_async_reset();
        restart();
        for (int k = 0; k < 30; k++) @(negedge CLK);
        total_cnt++;
        if (An !== 4'h7) $display("FAIL arst_pre_an got %h want 7", An); else pass_cnt++;
        #2;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (An !== 4'hF) $display("FAIL arst_an got %h want F", An); else pass_cnt++;
        total_cnt++;
        if (Seg !== 7'h7F) $display("FAIL arst_seg got %h want 7F", Seg); else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            total_cnt++;
            if (An !== exp_an(k, 1'b1) || Seg !== exp_seg(k, 1'b1))
                $display("FAIL arst_rel k=%0d got %h/%h want %h/%h", k, An, Seg, exp_an(k, 1'b1), exp_seg(k, 1'b1));
            else pass_cnt++;
        end
        $display("test_async_reset done");
    endtask

    initial begin
        pats[0] = 7'h40;
        pats[1] = 7'h79;
        pats[2] = 7'h24;
        pats[3] = 7'h30;
        test_reset();
        test_scan();
        test_dp();
        test_brightness();
        test_midslot_change();
        test_enable_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed 4-digit 7-segment LED driver, directly downstream of the hex segment decoder.
- Takes the four active-low 7-bit patterns (dg1..dg4) plus decimal-point requests and drives the shared segment bus and four active-low digit anodes.
- Scans one digit per slot, with inter-digit blanking to prevent ghosting and 4-bit PWM brightness control.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range 4..2^20.
- BLANK_CYC, 500, cycles at the start of each slot with all digits off; legal range 1..SCAN_DIV-1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- Enable  input  1  1 = scanning; 0 = display dark and scan state cleared.
- dg1  input  7  digit 0 segment pattern, active low (0 = lit), bit0 = seg a.
- dg2  input  7  digit 1 pattern, same encoding.
- dg3  input  7  digit 2 pattern, same encoding.
- dg4  input  7  digit 3 pattern, same encoding.
- DpIn  input  4  decimal point request per digit, active high; bit i belongs to digit i.
- Brightness  input  4  PWM level; 0 = off, 15 = full on.
- Seg  output  7  shared segment bus, active low.
- Dp  output  1  shared decimal-point segment, active low.
- An  output  4  digit anode enables, active low; An[i] selects digit i.
- FrameTick  output  1  one-cycle pulse at the start of each 4-digit frame.

Behaviour:
- Reset (RST high, asynchronous):
  - Seg = 7'h7F, Dp = 1, An = 4'hF, FrameTick = 0.
  - Slot counter Cnt = 0, digit index Idx = 0, PWM counter Pwm = 0, latched pattern = 7'h7F, latched dp = 0.
- Cnt advances 0..SCAN_DIV-1 every clock while Enable = 1.
  - When Cnt = SCAN_DIV-1: Cnt wraps to 0 and Idx advances 0->1->2->3->0.
- Capture: on the clock where Cnt = 0, the pattern for the current Idx (Idx 0 = dg1 … Idx 3 = dg4) and DpIn[Idx] are latched. Input changes mid-slot have no effect until the next slot's capture.
- Pwm is a 4-bit free-running counter (wraps 15->0) while Enable = 1.
  - Gate = 1 when Brightness = 15, otherwise gate = (Pwm < Brightness).
  - Brightness 0 keeps every anode off.
- Slot active condition: Cnt >= BLANK_CYC and gate = 1.
- All outputs are registered, with 1-cycle latency from the internal state in the same cycle:
  - Active: An = ~(4'b0001 << Idx), Seg = latched pattern, Dp = ~latched dp.
  - Inactive: An = 4'hF, Seg = 7'h7F, Dp = 1.
  - No anode is ever asserted with a stale pattern from another digit; at most one An bit is low in any cycle.
- FrameTick = 1 for exactly one cycle, on the clock after the cycle in which Cnt = SCAN_DIV-1 and Idx = 3. Pulse period = 4*SCAN_DIV cycles.
- Enable = 0, synchronous:
  - Next clock: Cnt = 0, Idx = 0, Pwm = 0, An = 4'hF, Seg = 7'h7F, Dp = 1, FrameTick = 0.
  - Latches are held.
- Enable 0->1: the scan restarts at digit 0 with a full blanking window; a capture occurs at Cnt = 0.
- Brightness changes take effect on the next clock; no slot restart.
- RST asserted mid-slot immediately forces the reset values. After release, the first capture is for digit 0.

Test Plan (bench uses SCAN_DIV = 8, BLANK_CYC = 2):
- Reset then Enable = 1, dg1..dg4 = 7'h40/7'h79/7'h24/7'h30 ("0123"), Brightness = 15, DpIn = 0:
  - Each slot: An = F for 2 cycles (plus 1 latency), then E/D/B/7 for 6 cycles with Seg = 40/79/24/30 respectively.
  - FrameTick pulses every 32 cycles.
- DpIn = 4'b0100: Dp = 0 only while An = 4'hB; Dp = 1 at all other times.
- Brightness = 4 at full-slot observation: in the active window An is low only when Pwm is 0..3, i.e. 4 of every 16 cycles. Brightness = 0: An stays 4'hF indefinitely.
- Change dg2 from 7'h79 to 7'h00 mid-way through digit 1's active window: Seg remains 7'h79 until digit 1's next slot, then shows 7'h00.
- Enable dropped mid-slot at Idx = 2: next clock An = F, Seg = 7F. Re-enable: the first active anode is An = E after the blank window.
- Assert RST asynchronously between clock edges while An = 4'h7: An = F and Seg = 7F immediately, without waiting for a clock edge. After release with Enable = 1, the first active digit is 0.
